// File: rtl/regs.sv
// 32 x 32-bit register file: two combinational read ports with write-through bypass, x0 fixed at 0.
// Define REGS_DBG_EN to add a third (debug) read port with the same read rules.
module regs (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  reg1_raddr_i,
    input  logic [4:0]  reg2_raddr_i,
    output logic [31:0] reg1_rdata_o,
    output logic [31:0] reg2_rdata_o,
`ifdef REGS_DBG_EN
    input  logic [4:0]  dbg_raddr_i,
    output logic [31:0] dbg_rdata_o,
`endif
    input  logic        reg_wen_i,
    input  logic [4:0]  reg_waddr_i,
    input  logic [31:0] reg_wdata_i
);

    logic [31:0] regs_q [32];
    logic        wr_en;

    assign wr_en = reg_wen_i && (reg_waddr_i != 5'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[reg_waddr_i] <= reg_wdata_i;
        end
    end

    // Read priority: reset or x0 -> 0, then bypass of the in-flight write, then storage.
    function automatic logic [31:0] read_sel(
        input logic [4:0]  addr,
        input logic [31:0] stored,
        input logic        rst_act,
        input logic        wen,
        input logic [4:0]  waddr,
        input logic [31:0] wdata
    );
        logic [31:0] data;
        data = stored;
        if (rst_act || (addr == 5'd0)) begin
            data = '0;
        end else if (wen && (waddr == addr)) begin
            data = wdata;
        end
        return data;
    endfunction

    always_comb begin
        reg1_rdata_o = read_sel(reg1_raddr_i, regs_q[reg1_raddr_i], !rst_n,
                                reg_wen_i, reg_waddr_i, reg_wdata_i);
    end

    always_comb begin
        reg2_rdata_o = read_sel(reg2_raddr_i, regs_q[reg2_raddr_i], !rst_n,
                                reg_wen_i, reg_waddr_i, reg_wdata_i);
    end

`ifdef REGS_DBG_EN
    always_comb begin
        dbg_rdata_o = read_sel(dbg_raddr_i, regs_q[dbg_raddr_i], !rst_n,
                               reg_wen_i, reg_waddr_i, reg_wdata_i);
    end
`endif

endmodule

// File: tb/tb_regs.sv
// Self-checking bench for regs: directed vector table plus hand sequences for reset corners.
module tb_regs;

    logic        clk;
    logic        rst_n;
    logic [4:0]  reg1_raddr_i;
    logic [4:0]  reg2_raddr_i;
    logic [31:0] reg1_rdata_o;
    logic [31:0] reg2_rdata_o;
    logic        reg_wen_i;
    logic [4:0]  reg_waddr_i;
    logic [31:0] reg_wdata_i;
`ifdef REGS_DBG_EN
    logic [4:0]  dbg_raddr_i;
    logic [31:0] dbg_rdata_o;
`endif

    int n_tests;
    int n_fail;

    regs dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .reg1_raddr_i (reg1_raddr_i),
        .reg2_raddr_i (reg2_raddr_i),
        .reg1_rdata_o (reg1_rdata_o),
        .reg2_rdata_o (reg2_rdata_o),
`ifdef REGS_DBG_EN
        .dbg_raddr_i  (dbg_raddr_i),
        .dbg_rdata_o  (dbg_rdata_o),
`endif
        .reg_wen_i    (reg_wen_i),
        .reg_waddr_i  (reg_waddr_i),
        .reg_wdata_i  (reg_wdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic wen, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] ra1, input logic [4:0] ra2);
        reg_wen_i    = wen;
        reg_waddr_i  = wa;
        reg_wdata_i  = wd;
        reg1_raddr_i = ra1;
        reg2_raddr_i = ra2;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
`ifdef REGS_DBG_EN
        dbg_raddr_i = '0;
`endif
        // Outputs are sampled #1 after driving at the negedge; writes commit at the next posedge.
        vecs[0]  = '{1'b1, 5'd5,  32'h12345678, 5'd5,  5'd5,  32'h12345678, 32'h12345678};
        vecs[1]  = '{1'b0, 5'd5,  32'h0,        5'd5,  5'd5,  32'h12345678, 32'h12345678};
        vecs[2]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h0,        32'h0};
        vecs[3]  = '{1'b0, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd5,  32'h0,        32'h12345678};
        vecs[4]  = '{1'b1, 5'd8,  32'h00000011, 5'd8,  5'd0,  32'h00000011, 32'h0};
        vecs[5]  = '{1'b1, 5'd7,  32'hA5A5A5A5, 5'd7,  5'd8,  32'hA5A5A5A5, 32'h00000011};
        vecs[6]  = '{1'b0, 5'd7,  32'h00000000, 5'd7,  5'd8,  32'hA5A5A5A5, 32'h00000011};
        vecs[7]  = '{1'b1, 5'd9,  32'h00000001, 5'd9,  5'd9,  32'h00000001, 32'h00000001};
        vecs[8]  = '{1'b1, 5'd9,  32'h00000002, 5'd9,  5'd7,  32'h00000002, 32'hA5A5A5A5};
        vecs[9]  = '{1'b1, 5'd9,  32'h00000003, 5'd9,  5'd9,  32'h00000003, 32'h00000003};
        vecs[10] = '{1'b0, 5'd9,  32'h00000077, 5'd9,  5'd31, 32'h00000003, 32'h0};
        vecs[11] = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd1,  32'hCAFEF00D, 32'h0};
        vecs[12] = '{1'b0, 5'd31, 32'h0000DEAD, 5'd31, 5'd31, 32'hCAFEF00D, 32'hCAFEF00D};

        // Reset with a write presented: bypass suppressed, write lost.
        rst_n = 1'b0;
        drive(1'b1, 5'd3, 32'h0BADF00D, 5'd3, 5'd3);
        #1;
        check("rst_bypass_p1", reg1_rdata_o, 32'h0);
        check("rst_bypass_p2", reg2_rdata_o, 32'h0);
        @(negedge clk);
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
        rst_n = 1'b1;
        #1;
        check("rst_write_lost", reg1_rdata_o, 32'h0);

        for (int a = 0; a < 32; a++) begin
            drive(1'b0, 5'd0, 32'h0, 5'(a), 5'(31 - a));
            #1;
            check($sformatf("reset_p1_x%0d", a), reg1_rdata_o, 32'h0);
            check($sformatf("reset_p2_x%0d", 31 - a), reg2_rdata_o, 32'h0);
        end

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            drive(vecs[i].wen, vecs[i].waddr, vecs[i].wdata, vecs[i].ra1, vecs[i].ra2);
            #1;
            check($sformatf("vec%0d_p1", i), reg1_rdata_o, vecs[i].exp1);
            check($sformatf("vec%0d_p2", i), reg2_rdata_o, vecs[i].exp2);
        end

`ifdef REGS_DBG_EN
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd7);
        dbg_raddr_i = 5'd31;
        #1;
        check("dbg_x31", dbg_rdata_o, 32'hCAFEF00D);
        check("dbg_p1_unaffected", reg1_rdata_o, 32'h00000003);
        check("dbg_p2_unaffected", reg2_rdata_o, 32'hA5A5A5A5);
        drive(1'b1, 5'd12, 32'h5555AAAA, 5'd9, 5'd7);
        dbg_raddr_i = 5'd12;
        #1;
        check("dbg_bypass", dbg_rdata_o, 32'h5555AAAA);
        dbg_raddr_i = 5'd0;
        #1;
        check("dbg_x0", dbg_rdata_o, 32'h0);
`endif

        // Mid-stream asynchronous reset between edges.
        @(negedge clk);
        drive(1'b1, 5'd3, 32'hDEADBEEF, 5'd3, 5'd5);
        @(posedge clk);
        #2;
        drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd5);
        #1;
        check("x3_written", reg1_rdata_o, 32'hDEADBEEF);
        rst_n = 1'b0;
        #1;
        check("async_rst_x3", reg1_rdata_o, 32'h0);
        @(negedge clk);
        drive(1'b1, 5'd4, 32'h44444444, 5'd4, 5'd4);
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 5'd4, 5'd9);
        rst_n = 1'b1;
        #1;
        check("rst_write_x4_lost", reg1_rdata_o, 32'h0);
        check("rst_clears_x9", reg2_rdata_o, 32'h0);
        drive(1'b0, 5'd0, 32'h0, 5'd31, 5'd7);
        #1;
        check("rst_clears_x31", reg1_rdata_o, 32'h0);
        check("rst_clears_x7", reg2_rdata_o, 32'h0);

        // First write after release is accepted on the next rising edge.
        drive(1'b1, 5'd6, 32'h66666666, 5'd1, 5'd2);
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 5'd6, 5'd6);
        #1;
        check("first_write_p1", reg1_rdata_o, 32'h66666666);
        check("first_write_p2", reg2_rdata_o, 32'h66666666);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
